// File: rtl/lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl
//   Load/store bus controller between the M-stage and the data-memory/bridge
//   bus. It checks alignment, builds lane byte-enables, replicates store data
//   onto the lanes and runs a req/gnt/rvalid handshake. It returns the raw
//   bus word plus byteen/ext_op for the downstream load extender. Only one
//   access is outstanding at a time. The M-stage stalls while req_ready=0.
//
// Parameters
//   TIMEOUT     max cycles spent in REQ+RESP before aborting (1..255)
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   flush               cancel the current access
//   req_valid/ready     M-stage request handshake
//   req_we/size/sign    store flag, size (00 b, 01 h, 10 w, 11 illegal), sign
//   req_addr/wdata      byte address, low-aligned store data
//   bus_req/we/addr     bus request (held until gnt), write flag, word address
//   bus_byteen/wdata    active lanes, lane-replicated store data
//   bus_gnt/rvalid      bus accept and response strobes
//   bus_rdata           bus read data
//   rsp_valid           one-cycle completion pulse
//   rsp_data/byteen     raw bus word (0 for stores/errors), access lanes
//   rsp_ext_op          registered sign request (0 for stores)
//   rsp_err             00 ok, 01 misaligned/illegal size, 10 bus timeout
// -----------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_byteen,
    output logic        rsp_ext_op,
    output logic [1:0]  rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        sign_q, sign_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        drop_q, drop_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_byteen_q, rsp_byteen_d;
    logic        rsp_ext_op_q, rsp_ext_op_d;
    logic [1:0]  rsp_err_q, rsp_err_d;

    logic [3:0]  byteen_new;
    logic [31:0] wdata_new;
    logic        misaligned;
    logic [7:0]  cnt_inc;
    logic        timed_out;

    // Lane decode of the incoming request; size 11 has no lanes and is
    // always reported as an alignment error.
    always_comb begin
        byteen_new = 4'b0000;
        wdata_new  = req_wdata;
        misaligned = 1'b0;
        case (req_size)
            2'b00: begin
                byteen_new = 4'b0001 << req_addr[1:0];
                wdata_new  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byteen_new = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{req_wdata[15:0]}};
                misaligned = req_addr[0];
            end
            2'b10: begin
                byteen_new = 4'b1111;
                misaligned = |req_addr[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // The counter saturates so a grant on the last allowed cycle cannot wrap
    // it back to zero while waiting for rvalid.
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timed_out = (cnt_q >= TIMEOUT_LAST);

    // Next-state logic. The rsp_* registers are only loaded on the
    // transition into DONE so they hold their value until the next DONE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        sign_d       = sign_q;
        byteen_d     = byteen_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        drop_d       = drop_q;
        rsp_data_d   = rsp_data_q;
        rsp_byteen_d = rsp_byteen_q;
        rsp_ext_op_d = rsp_ext_op_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = 8'd0;
                drop_d = 1'b0;
                if (req_valid && !flush) begin
                    addr_d   = req_addr[31:2];
                    we_d     = req_we;
                    sign_d   = req_sign;
                    byteen_d = byteen_new;
                    wdata_d  = wdata_new;
                    if (misaligned) begin
                        state_d      = ST_DONE;
                        rsp_data_d   = 32'd0;
                        rsp_byteen_d = byteen_new;
                        rsp_ext_op_d = req_sign & ~req_we;
                        rsp_err_d    = 2'b01;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_inc;
                if (bus_gnt) begin
                    // Bus has taken the request; it must be allowed to finish.
                    state_d = ST_RESP;
                    if (flush) begin
                        drop_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d      = ST_DONE;
                    rsp_data_d   = 32'd0;
                    rsp_byteen_d = byteen_q;
                    rsp_ext_op_d = sign_q & ~we_q;
                    rsp_err_d    = 2'b10;
                end
            end

            ST_RESP: begin
                cnt_d = cnt_inc;
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (bus_rvalid) begin
                    state_d      = ST_DONE;
                    rsp_data_d   = we_q ? 32'd0 : bus_rdata;
                    rsp_byteen_d = byteen_q;
                    rsp_ext_op_d = sign_q & ~we_q;
                    rsp_err_d    = 2'b00;
                end else if (timed_out) begin
                    state_d      = ST_DONE;
                    rsp_data_d   = 32'd0;
                    rsp_byteen_d = byteen_q;
                    rsp_ext_op_d = sign_q & ~we_q;
                    rsp_err_d    = 2'b10;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                drop_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE immediately, abandoning any
    // access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 30'd0;
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            byteen_q     <= 4'b0000;
            wdata_q      <= 32'd0;
            cnt_q        <= 8'd0;
            drop_q       <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_byteen_q <= 4'b0000;
            rsp_ext_op_q <= 1'b0;
            rsp_err_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            sign_q       <= sign_d;
            byteen_q     <= byteen_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            drop_q       <= drop_d;
            rsp_data_q   <= rsp_data_d;
            rsp_byteen_q <= rsp_byteen_d;
            rsp_ext_op_q <= rsp_ext_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign bus_req    = (state_q == ST_REQ);
    assign bus_we     = we_q;
    assign bus_addr   = {addr_q, 2'b00};
    assign bus_byteen = byteen_q;
    assign bus_wdata  = wdata_q;

    // A flush arriving in DONE itself also suppresses the pulse.
    assign rsp_valid  = (state_q == ST_DONE) && !drop_q && !flush;
    assign rsp_data   = rsp_data_q;
    assign rsp_byteen = rsp_byteen_q;
    assign rsp_ext_op = rsp_ext_op_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_ctrl
//   Self-checking bench for lsu_bus_ctrl (TIMEOUT=8). Table-driven accesses
//   with a one-cycle gnt/rvalid bus, plus hand-written multi-cycle sequences
//   for timeout, flush, late rvalid and reset-in-flight behaviour.
// -----------------------------------------------------------------------------
module tb_lsu_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_byteen;
    logic        rsp_ext_op;
    logic [1:0]  rsp_err;

    int checks = 0;
    int errors = 0;

    lsu_bus_ctrl #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_byteen (rsp_byteen),
        .rsp_ext_op (rsp_ext_op),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        bad;
        logic [31:0] exp_addr;
        logic [3:0]  exp_byteen;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_ext;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_sign   = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
    endtask

    // Drives a request in the current cycle; called at posedge+1.
    task automatic drive_req(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One table entry: accept at N, gnt at N+1, rvalid at N+2, rsp at N+3.
    task automatic applyStimulus(input int i);
        vec_t v;
        v = vecs[i];
        drive_req(v.we, v.size, v.sign, v.addr, v.wdata);
        @(negedge clk);
        check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        if (v.bad) begin
            @(negedge clk);
            check($sformatf("v%0d_no_bus_req", i), 32'(bus_req), 32'd0);
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(v.exp_err));
            check($sformatf("v%0d_rsp_data", i), rsp_data, 32'd0);
            next_cycle();
        end else begin
            bus_gnt = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_bus_req", i), 32'(bus_req), 32'd1);
            check($sformatf("v%0d_bus_we", i), 32'(bus_we), 32'(v.we));
            check($sformatf("v%0d_bus_addr", i), bus_addr, v.exp_addr);
            check($sformatf("v%0d_bus_byteen", i), 32'(bus_byteen), 32'(v.exp_byteen));
            if (v.we) check($sformatf("v%0d_bus_wdata", i), bus_wdata, v.exp_wdata);
            next_cycle();
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = v.rdata;
            @(negedge clk);
            check($sformatf("v%0d_req_dropped", i), 32'(bus_req), 32'd0);
            check($sformatf("v%0d_no_early_rsp", i), 32'(rsp_valid), 32'd0);
            next_cycle();
            bus_rvalid = 1'b0;
            bus_rdata  = 32'd0;
            checkOutput(i);
            next_cycle();
        end
        @(negedge clk);
        check($sformatf("v%0d_rsp_pulse_end", i), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_ready_again", i), 32'(req_ready), 32'd1);
        next_cycle();
    endtask

    task automatic checkOutput(input int i);
        @(negedge clk);
        check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
        check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
        check($sformatf("v%0d_rsp_byteen", i), 32'(rsp_byteen), 32'(vecs[i].exp_byteen));
        check($sformatf("v%0d_rsp_ext_op", i), 32'(rsp_ext_op), 32'(vecs[i].exp_ext));
        check($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
    endtask

    initial begin
        int  n_req;
        bit  got;

        //          we    size   sign  addr          wdata         rdata         bad   exp_addr      byteen   exp_wdata     exp_data      ext   err
        vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h00001004, 32'h12345678, 32'hDEADBEEF, 1'b0, 32'h00001004, 4'b1111, 32'h12345678, 32'hDEADBEEF, 1'b0, 2'b00};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h00001003, 32'h000000AA, 32'h80000000, 1'b0, 32'h00001000, 4'b1000, 32'hAAAAAAAA, 32'h80000000, 1'b1, 2'b00};
        vecs[2] = '{1'b1, 2'b01, 1'b1, 32'h00002002, 32'h0000ABCD, 32'h55555555, 1'b0, 32'h00002000, 4'b1100, 32'hABCDABCD, 32'h00000000, 1'b0, 2'b00};
        vecs[3] = '{1'b1, 2'b00, 1'b0, 32'h00003001, 32'h12345677, 32'h11111111, 1'b0, 32'h00003000, 4'b0010, 32'h77777777, 32'h00000000, 1'b0, 2'b00};
        vecs[4] = '{1'b0, 2'b01, 1'b0, 32'h00004000, 32'h00000000, 32'hCAFEF00D, 1'b0, 32'h00004000, 4'b0011, 32'h00000000, 32'hCAFEF00D, 1'b0, 2'b00};
        vecs[5] = '{1'b0, 2'b01, 1'b0, 32'h00002001, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 2'b01};
        vecs[6] = '{1'b0, 2'b10, 1'b0, 32'h00005002, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 2'b01};
        vecs[7] = '{1'b1, 2'b11, 1'b0, 32'h00006000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 2'b01};
        vecs[8] = '{1'b1, 2'b10, 1'b0, 32'h00007008, 32'h89ABCDEF, 32'h22222222, 1'b0, 32'h00007008, 4'b1111, 32'h89ABCDEF, 32'h00000000, 1'b0, 2'b00};

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_bus_req", 32'(bus_req), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_bus_byteen", 32'(bus_byteen), 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(i);
        end

        // Timeout: no grant ever; bus_req must stay high exactly 8 cycles.
        drive_req(1'b0, 2'b10, 1'b0, 32'h00008000, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        n_req = 0;
        got   = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                check("to_rsp_err", 32'(rsp_err), 32'd2);
                check("to_rsp_data", rsp_data, 32'd0);
                check("to_bus_req_low", 32'(bus_req), 32'd0);
            end else if (bus_req) begin
                n_req++;
            end
            next_cycle();
        end
        check("to_rsp_seen", 32'(got), 32'd1);
        check("to_req_cycles", 32'(n_req), 32'd8);

        // rvalid in the grant cycle is ignored; the later one completes.
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000A000, 32'd0);
        next_cycle();
        req_valid  = 1'b0;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0BADF00D;
        next_cycle();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("gr_no_rsp_n2", 32'(rsp_valid), 32'd0);
        next_cycle();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h600DCAFE;
        @(negedge clk);
        check("gr_no_rsp_n3", 32'(rsp_valid), 32'd0);
        next_cycle();
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("gr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("gr_rsp_data", rsp_data, 32'h600DCAFE);
        next_cycle();

        // Flush in RESP: bus completes but no response pulse.
        drive_req(1'b0, 2'b10, 1'b0, 32'h00009000, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        bus_gnt   = 1'b1;
        next_cycle();
        bus_gnt = 1'b0;
        flush   = 1'b1;
        next_cycle();
        flush      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h13572468;
        next_cycle();
        bus_rvalid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            next_cycle();
        end
        check("fr_no_rsp", 32'(got), 32'd0);
        @(negedge clk);
        check("fr_ready", 32'(req_ready), 32'd1);
        next_cycle();

        // Flush in REQ before grant: straight back to IDLE.
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000B000, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        flush     = 1'b1;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("fq_bus_req", 32'(bus_req), 32'd0);
        check("fq_ready", 32'(req_ready), 32'd1);
        check("fq_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Flush in IDLE blocks acceptance.
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000C000, 32'd0);
        flush = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("fi_bus_req", 32'(bus_req), 32'd0);
        check("fi_ready", 32'(req_ready), 32'd1);
        next_cycle();

        // Flush during DONE suppresses the pulse.
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000D000, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        bus_gnt   = 1'b1;
        next_cycle();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        next_cycle();
        bus_rvalid = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        check("fd_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        flush = 1'b0;

        // Reset asserted in REQ: outputs go idle at once; late rvalid ignored.
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000E000, 32'h0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("rr_bus_req_before", 32'(bus_req), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rr_bus_req_now", 32'(bus_req), 32'd0);
        check("rr_ready_now", 32'(req_ready), 32'd1);
        next_cycle();
        reset      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        check("rr_late_rvalid_rsp", 32'(rsp_valid), 32'd0);
        next_cycle();
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("rr_late_rvalid_rsp2", 32'(rsp_valid), 32'd0);
        check("rr_ready_after", 32'(req_ready), 32'd1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
